atb_funnel: RTL

Merges NUM_SRC ATB trace sources onto a single ATB master port toward the trace sink. Implements round-robin arbitration with a bounded hold count, flush fan-out/fan-in and syncreq broadcast. Sits between the per-source trace generators (tx side) and the downstream ATB receiver; the payload path is zero-latency and only grant/flush state is registered.

---
 rtl/atb_pkg.sv | 31 +++
 rtl/atb_funnel_if.sv | 42 ++++
 rtl/atb_rr_arbiter.sv | 27 ++
 rtl/atb_funnel.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/atb_pkg.sv
// Shared ATB widths, payload type and FSM state encodings for the trace funnel.
package atb_pkg;

  localparam int unsigned ATB_DATA_W  = 32;
  localparam int unsigned ATB_BYTES_W = 2;
  localparam int unsigned ATB_ID_W    = 7;

  typedef struct packed {
    logic [ATB_DATA_W-1:0]  data;
    logic [ATB_BYTES_W-1:0] bytes;
    logic [ATB_ID_W-1:0]    id;
  } atb_payload_t;

  typedef enum logic {
    G_IDLE,
    G_GRANT
  } grant_state_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_DRAIN,
    F_DONE,
    F_WAIT
  } flush_state_e;

  // Next port index after v, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/atb_funnel_if.sv
// ATB bundle for the funnel: NUM_SRC slave-side sources plus the single merged master port.
interface atb_funnel_if
  import atb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
);

  logic [NUM_SRC-1:0][ATB_DATA_W-1:0]  s_atdata;
  logic [NUM_SRC-1:0][ATB_BYTES_W-1:0] s_atbytes;
  logic [NUM_SRC-1:0][ATB_ID_W-1:0]    s_atid;
  logic [NUM_SRC-1:0]                  s_atvalid;
  logic [NUM_SRC-1:0]                  s_atready;
  logic [NUM_SRC-1:0]                  s_afvalid;
  logic [NUM_SRC-1:0]                  s_afready;
  logic [NUM_SRC-1:0]                  s_syncreq;

  logic [ATB_DATA_W-1:0]               m_atdata;
  logic [ATB_BYTES_W-1:0]              m_atbytes;
  logic [ATB_ID_W-1:0]                 m_atid;
  logic                                m_atvalid;
  logic                                m_atready;
  logic                                m_afvalid;
  logic                                m_afready;
  logic                                m_syncreq;

  // Funnel view: consumes source beats, produces the merged stream.
  modport master (
    input  s_atdata, s_atbytes, s_atid, s_atvalid, s_afready,
    input  m_atready, m_afvalid, m_syncreq,
    output s_atready, s_afvalid, s_syncreq,
    output m_atdata, m_atbytes, m_atid, m_atvalid, m_afready
  );

  // Environment view: trace sources and downstream sink.
  modport slave (
    output s_atdata, s_atbytes, s_atid, s_atvalid, s_afready,
    output m_atready, m_afvalid, m_syncreq,
    input  s_atready, s_afvalid, s_syncreq,
    input  m_atdata, m_atbytes, m_atid, m_atvalid, m_afready
  );

endinterface

// File: rtl/atb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module atb_rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx_c,
  output logic               any_c
);

  int unsigned idx;

  always_comb begin
    gnt_idx_c = '0;
    any_c     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      idx = (32'(ptr) + off) % NUM_SRC;
      if (!any_c && req[idx]) begin
        any_c     = 1'b1;
        gnt_idx_c = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/atb_funnel.sv
// ATB trace funnel: round-robin merge of NUM_SRC sources with bounded hold,
// flush fan-out/fan-in and syncreq broadcast. Payload path is zero-latency.
module atb_funnel
  import atb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned HOLD    = 4
) (
  input  logic               atclk,
  input  logic               atresetn,
  input  logic               atclken,
  input  logic [NUM_SRC-1:0] cfg_en,
  atb_funnel_if.master       bus
);

  localparam int unsigned IDX_W = $clog2(NUM_SRC);
  localparam int unsigned CNT_W = 4;

  grant_state_e       gstate, gstate_n;
  logic [IDX_W-1:0]   gnt, gnt_n;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;

  flush_state_e       fstate, fstate_n;
  logic [NUM_SRC-1:0] done, done_n;
  logic [NUM_SRC-1:0] syncreq;

  logic [NUM_SRC-1:0] req_c;
  logic [IDX_W-1:0]   arb_ptr_c;
  logic [IDX_W-1:0]   arb_idx_c;
  logic               arb_any_c;

  logic               granted_c;
  logic               cur_valid_c;
  logic               hs_c;
  logic               rearb_c;
  atb_payload_t       pay_c;
  logic               m_atvalid_c;
  logic [NUM_SRC-1:0] s_atready_c;
  logic [NUM_SRC-1:0] s_afvalid_c;
  logic [NUM_SRC-1:0] ack_done_c;
  logic               all_done_c;

  assign req_c       = bus.s_atvalid & cfg_en;
  assign granted_c   = (gstate == G_GRANT);
  assign cur_valid_c = bus.s_atvalid[gnt];
  assign arb_ptr_c   = granted_c ? IDX_W'(wrap_inc(32'(gnt), NUM_SRC)) : rr_ptr;

  atb_rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_c),
    .ptr       (arb_ptr_c),
    .gnt_idx_c (arb_idx_c),
    .any_c     (arb_any_c)
  );

  // Grant state registers
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      gstate   <= G_IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      gstate   <= gstate_n;
      gnt      <= gnt_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  // Grant next-state and merged-port muxing; a pending beat on the granted
  // source pins the grant until it is accepted.
  always_comb begin
    gstate_n    = gstate;
    gnt_n       = gnt;
    rr_ptr_n    = rr_ptr;
    beat_cnt_n  = beat_cnt;
    pay_c       = '0;
    m_atvalid_c = 1'b0;
    s_atready_c = '0;
    hs_c        = 1'b0;
    rearb_c     = 1'b0;

    if (granted_c) begin
      pay_c.data  = bus.s_atdata[gnt];
      pay_c.bytes = bus.s_atbytes[gnt];
      pay_c.id    = bus.s_atid[gnt];
      m_atvalid_c = cur_valid_c;
      s_atready_c = NUM_SRC'(bus.m_atready) << gnt;
      hs_c        = atclken & cur_valid_c & bus.m_atready;
      rearb_c     = !cur_valid_c
                  | (hs_c & ((beat_cnt == CNT_W'(HOLD - 1)) | !cfg_en[gnt]));
    end

    if (atclken) begin
      case (gstate)
        G_IDLE: begin
          if (arb_any_c) begin
            gstate_n   = G_GRANT;
            gnt_n      = arb_idx_c;
            rr_ptr_n   = IDX_W'(wrap_inc(32'(arb_idx_c), NUM_SRC));
            beat_cnt_n = '0;
          end
        end
        G_GRANT: begin
          if (rearb_c) begin
            beat_cnt_n = '0;
            if (arb_any_c) begin
              gnt_n    = arb_idx_c;
              rr_ptr_n = IDX_W'(wrap_inc(32'(arb_idx_c), NUM_SRC));
            end else begin
              gstate_n = G_IDLE;
            end
          end else if (hs_c) begin
            beat_cnt_n = beat_cnt + CNT_W'(1);
          end
        end
        default: gstate_n = G_IDLE;
      endcase
    end
  end

  // Flush state registers
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      fstate <= F_IDLE;
      done   <= '0;
    end else begin
      fstate <= fstate_n;
      done   <= done_n;
    end
  end

  // Flush fan-out/fan-in; the acknowledging cycle counts toward completion.
  always_comb begin
    fstate_n    = fstate;
    done_n      = done;
    s_afvalid_c = (fstate == F_DRAIN) ? (cfg_en & ~done) : '0;
    ack_done_c  = done | (bus.s_afready & s_afvalid_c);
    all_done_c  = &(ack_done_c | ~cfg_en);

    if (atclken) begin
      case (fstate)
        F_IDLE: begin
          done_n = '0;
          if (bus.m_afvalid) fstate_n = F_DRAIN;
        end
        F_DRAIN: begin
          done_n = ack_done_c;
          if (all_done_c && !m_atvalid_c) fstate_n = F_DONE;
        end
        F_DONE:  fstate_n = F_WAIT;
        F_WAIT:  if (!bus.m_afvalid) fstate_n = F_IDLE;
        default: fstate_n = F_IDLE;
      endcase
    end
  end

  // One-cycle syncreq broadcast
  always_ff @(posedge atclk or negedge atresetn) begin
    if (!atresetn) begin
      syncreq <= '0;
    end else if (atclken) begin
      syncreq <= {NUM_SRC{bus.m_syncreq}};
    end
  end

  assign bus.m_atdata  = pay_c.data;
  assign bus.m_atbytes = pay_c.bytes;
  assign bus.m_atid    = pay_c.id;
  assign bus.m_atvalid = m_atvalid_c;
  assign bus.s_atready = s_atready_c;
  assign bus.s_afvalid = s_afvalid_c;
  assign bus.m_afready = (fstate == F_DONE);
  assign bus.s_syncreq = syncreq;

endmodule
